mac_tx_arbiter: RTL and testbench
=================================

// Module: mac_tx_arbiter
// PURPOSE
// - Packet-level arbiter between the UDP/MAC data TX stream (ch0) and the ARP TX stream (ch1); feeds mac_tx_top.
// - Buffers each stream in its own FIFO and releases only complete packets.
// - Alternates grants between channels and paces bytes to the RMII rate.
// - Enforces an inter-frame gap between packets; the output stream is never interleaved.
// PARAMETERS
// - DEPTH0       2048  ch0 FIFO depth, entries of {sop,eop,dat[7:0]} (10 bits)
// - DEPTH1       128   ch1 FIFO depth, entries of 10 bits
// - MAX_PKT0     1514  max ch0 packet bytes; free space required at sop to admit
// - MAX_PKT1     64    max ch1 packet bytes; free space required at sop to admit
// - BYTE_DIV     4     clocks per output byte (2 bit/clk RMII)
// - IFG_CYCLES   48    idle clocks after the eop byte before the next grant (12 bytes x 4)
// PORTS
// - i_clk                 in   1  system clock
// - i_rst                 in   1  synchronous reset, active-high
// - i_mac_packet_tx_sop   in   1  ch0 first byte
// - i_mac_packet_tx_eop   in   1  ch0 last byte
// - i_mac_packet_tx_vld   in   1  ch0 byte valid
// - i_mac_packet_tx_dat   in   8  ch0 byte
// - i_arp_tx_sop/eop/vld  in   1  ch1 controls, same meaning as ch0
// - i_arp_tx_dat          in   8  ch1 byte
// - o_mac_tx_sop          out  1  output first byte, asserted with vld
// - o_mac_tx_eop          out  1  output last byte, asserted with vld
// - o_mac_tx_vld          out  1  one-clock strobe per byte, every BYTE_DIV clocks
// - o_mac_tx_dat          out  8  output byte
// - o_drop                out  2  one-clock pulse per channel when a packet is rejected at sop
// - o_busy                out  1  high in SEND or GAP
// BEHAVIOUR
// - Reset (i_rst sampled high at an i_clk edge):
//   - all outputs 0; FIFOs empty; packet counters 0; FSM goes to IDLE; last_grant=1, so ch0 wins first.
// - Input admission (per channel, every clock):
//   - At vld&sop, admit the packet if free >= MAX_PKT, else drop the whole packet and pulse o_drop[ch].
//   - While admitted, write {sop,eop,dat} on each vld; the admit flag clears after the eop write.
//   - sop&eop in the same cycle is a legal 1-byte packet.
//   - vld outside an admitted packet is discarded.
// - Packet counter pcnt[ch]:
//   - +1 on an eop write; -1 on an eop read; both in the same cycle leave it unchanged.
//   - A channel is ready when pcnt != 0.
// - FSM:
//   - IDLE: go to ARB.
//   - ARB: if the channel other than last_grant is ready, grant it; otherwise grant last_grant if ready;
//     otherwise stay in ARB. On a grant, load last_grant and go to SEND.
//   - SEND: a byte divider counts 0..BYTE_DIV-1. Pop one FIFO entry when the divider is 0.
//     The registered output follows 1 clock after the pop (vld high for that single clock).
//     After popping the eop entry, go to GAP.
//   - GAP: count IFG_CYCLES clocks starting at the eop strobe, then go to ARB.
// - Throughput/latency:
//   - First o_mac_tx_vld comes 2 clocks after the eop write that made the channel ready (IDLE/ARB idle case).
//   - Packets are strictly serial; ch0 and ch1 strictly alternate when both are ready.
// - Boundary conditions:
//   - Simultaneous write and read on one FIFO is legal.
//   - Full FIFO cannot occur mid-packet, because of admission at sop.
//   - Pointers wrap modulo DEPTH; DEPTH must be a power of 2.
//   - Reset mid-SEND truncates the output with no eop; downstream mac_tx_top discards the frame (no FCS).
// - Widths: pointers and free-space counts are clog2(DEPTH)+1 bits; pcnt is clog2(DEPTH) bits (saturation impossible).
// STRUCTURE
// - Package mac_tx_pkg: FIFO entry layout (10 bits; SOP bit 9, EOP bit 8), FSM state enum, channel index constants.
// - Sub-module sync_fifo #(WIDTH,DEPTH): single-clock FIFO with free-count output; instantiated twice.
// - This module contains the admission logic, pcnt, arbiter FSM, byte divider, IFG counter and output registers.
// TESTING
// - Single ch1 60-byte packet after reset -> 60 vld strobes spaced 4 clocks, sop on byte 0, eop on byte 59, o_busy high.
// - ch0 100-byte and ch1 60-byte packets both ready -> ch0 first (reset grant), exactly 48 idle clocks, then ch1.
// - 3 ch1 packets plus 3 ch0 packets queued -> output order 0,1,0,1,0,1, bytes bit-exact.
// - ch1 free <64 at sop (fill with two undrained 64-byte packets) -> o_drop[1] pulses 1 clock, no bytes written.
// - 1-byte packet (sop=eop=vld=1) on ch0 -> a single strobe carrying sop=eop=1.
// - i_rst asserted at byte 30 of a 100-byte send -> next clock all outputs 0, FIFOs empty, a new packet sends cleanly.

Source files
------------

// File: rtl/mac_tx_pkg.sv
// -----------------------------------------------------------------------------
// mac_tx_pkg
// Shared types for the MAC TX arbiter: FIFO entry layout, arbiter FSM states
// and channel indices.
//   entry_t  : {sop, eop, dat[7:0]}  (sop = bit 9, eop = bit 8)
//   state_e  : IDLE / ARB / SEND / GAP
//   CH0/CH1  : ch0 = UDP/MAC data stream, ch1 = ARP stream
// -----------------------------------------------------------------------------
package mac_tx_pkg;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] dat;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead read data and a free-entry count.
//   i_clk, i_rst   : clock, synchronous active-high reset (empties the FIFO)
//   i_wr, i_wdat   : write strobe and data
//   i_rd           : pop strobe; o_rdat always shows the head entry
//   o_free         : number of free entries (0..DEPTH)
// DEPTH must be a power of 2; pointers carry one extra wrap bit.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 128
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdat,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdat,
  output logic [$clog2(DEPTH):0]   o_free
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_wr) r_wptr <= r_wptr + PTR_ONE;
      if (i_rd) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and a reset-free array maps onto RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr) r_mem[r_wptr[AW-1:0]] <= i_wdat;
  end

  assign o_rdat = r_mem[r_rptr[AW-1:0]];
  assign o_free = DEPTH_L - (r_wptr - r_rptr);

endmodule

// File: rtl/mac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mac_tx_arbiter
// Packet-level arbiter between the UDP/MAC data TX stream (ch0) and the ARP TX
// stream (ch1), feeding mac_tx_top. Each stream is buffered in its own FIFO
// and only complete packets are released. Grants alternate between channels,
// bytes are paced at one per BYTE_DIV clocks and an inter-frame gap of
// IFG_CYCLES clocks follows every packet.
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_mac_packet_tx_*         : ch0 input stream (sop/eop/vld/dat)
//   i_arp_tx_*                : ch1 input stream (sop/eop/vld/dat)
//   o_mac_tx_sop/eop/vld/dat  : serialized output, vld is a 1-clock strobe
//   o_drop[1:0]               : 1-clock pulse when a packet is refused at sop
//   o_busy                    : high while sending or in the inter-frame gap
// -----------------------------------------------------------------------------
module mac_tx_arbiter
  import mac_tx_pkg::*;
#(
  parameter int DEPTH0     = 2048,
  parameter int DEPTH1     = 128,
  parameter int MAX_PKT0   = 1514,
  parameter int MAX_PKT1   = 64,
  parameter int BYTE_DIV   = 4,
  parameter int IFG_CYCLES = 48
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_mac_packet_tx_sop,
  input  logic       i_mac_packet_tx_eop,
  input  logic       i_mac_packet_tx_vld,
  input  logic [7:0] i_mac_packet_tx_dat,
  input  logic       i_arp_tx_sop,
  input  logic       i_arp_tx_eop,
  input  logic       i_arp_tx_vld,
  input  logic [7:0] i_arp_tx_dat,
  output logic       o_mac_tx_sop,
  output logic       o_mac_tx_eop,
  output logic       o_mac_tx_vld,
  output logic [7:0] o_mac_tx_dat,
  output logic [1:0] o_drop,
  output logic       o_busy
);

  localparam int AW0   = $clog2(DEPTH0);
  localparam int AW1   = $clog2(DEPTH1);
  localparam int DIV_W = (BYTE_DIV > 1) ? $clog2(BYTE_DIV) : 1;
  localparam int IFG_W = $clog2(IFG_CYCLES + 1);

  localparam logic [AW0:0]       NEED0    = (AW0 + 1)'(MAX_PKT0);
  localparam logic [AW1:0]       NEED1    = (AW1 + 1)'(MAX_PKT1);
  localparam logic [AW0-1:0]     PCNT0_1  = AW0'(1);
  localparam logic [AW1-1:0]     PCNT1_1  = AW1'(1);
  localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(BYTE_DIV - 1);
  localparam logic [IFG_W-1:0]   IFG_ONE  = IFG_W'(1);
  localparam logic [IFG_W-1:0]   IFG_LAST = IFG_W'(IFG_CYCLES - 1);

  entry_t           w_in0, w_in1, w_rdat0, w_rdat1, w_head;
  logic             w_wr0, w_wr1, w_rd0, w_rd1;
  logic             w_fit0, w_fit1;
  logic [AW0:0]     w_free0;
  logic [AW1:0]     w_free1;
  logic             r_admit0, r_admit1;
  logic [AW0-1:0]   r_pcnt0;
  logic [AW1-1:0]   r_pcnt1;
  logic [1:0]       w_ready;
  state_e           r_state, w_state_nxt;
  logic             r_last_grant, w_grant, w_grant_ch;
  logic [DIV_W-1:0] r_div;
  logic [IFG_W-1:0] r_ifg;
  logic             w_pop;
  logic             r_vld, r_sop, r_eop;
  logic [7:0]       r_dat;
  logic [1:0]       r_drop;

  // ---------------- input admission -----------------------------------------
  // A packet is accepted only if the whole worst-case packet fits at sop, so a
  // FIFO can never fill mid-packet. Bytes outside an admitted packet are lost.
  assign w_in0  = {i_mac_packet_tx_sop, i_mac_packet_tx_eop, i_mac_packet_tx_dat};
  assign w_in1  = {i_arp_tx_sop, i_arp_tx_eop, i_arp_tx_dat};
  assign w_fit0 = (w_free0 >= NEED0);
  assign w_fit1 = (w_free1 >= NEED1);
  assign w_wr0  = i_mac_packet_tx_vld & (i_mac_packet_tx_sop ? w_fit0 : r_admit0);
  assign w_wr1  = i_arp_tx_vld & (i_arp_tx_sop ? w_fit1 : r_admit1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_admit0 <= 1'b0;
      r_admit1 <= 1'b0;
      r_drop   <= 2'b00;
    end else begin
      if (i_mac_packet_tx_vld & i_mac_packet_tx_sop)
        r_admit0 <= w_fit0 & ~i_mac_packet_tx_eop;
      else if (i_mac_packet_tx_vld & i_mac_packet_tx_eop)
        r_admit0 <= 1'b0;
      if (i_arp_tx_vld & i_arp_tx_sop)
        r_admit1 <= w_fit1 & ~i_arp_tx_eop;
      else if (i_arp_tx_vld & i_arp_tx_eop)
        r_admit1 <= 1'b0;
      r_drop[0] <= i_mac_packet_tx_vld & i_mac_packet_tx_sop & ~w_fit0;
      r_drop[1] <= i_arp_tx_vld & i_arp_tx_sop & ~w_fit1;
    end
  end

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH0)) u_fifo0 (
    .i_clk (i_clk), .i_rst (i_rst),
    .i_wr  (w_wr0), .i_wdat(w_in0),
    .i_rd  (w_rd0), .o_rdat(w_rdat0),
    .o_free(w_free0)
  );

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH1)) u_fifo1 (
    .i_clk (i_clk), .i_rst (i_rst),
    .i_wr  (w_wr1), .i_wdat(w_in1),
    .i_rd  (w_rd1), .o_rdat(w_rdat1),
    .o_free(w_free1)
  );

  // ---------------- complete-packet counters ---------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pcnt0 <= '0;
      r_pcnt1 <= '0;
    end else begin
      case ({w_wr0 & w_in0.eop, w_rd0 & w_rdat0.eop})
        2'b10:   r_pcnt0 <= r_pcnt0 + PCNT0_1;
        2'b01:   r_pcnt0 <= r_pcnt0 - PCNT0_1;
        default: r_pcnt0 <= r_pcnt0;
      endcase
      case ({w_wr1 & w_in1.eop, w_rd1 & w_rdat1.eop})
        2'b10:   r_pcnt1 <= r_pcnt1 + PCNT1_1;
        2'b01:   r_pcnt1 <= r_pcnt1 - PCNT1_1;
        default: r_pcnt1 <= r_pcnt1;
      endcase
    end
  end

  assign w_ready = {(r_pcnt1 != '0), (r_pcnt0 != '0)};

  // ---------------- arbiter FSM ----------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_ch  = r_last_grant;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_ARB;
      ST_ARB: begin
        // Prefer the channel that did not send last; fall back to the other.
        if (w_ready[~r_last_grant]) begin
          w_grant    = 1'b1;
          w_grant_ch = ~r_last_grant;
        end else if (w_ready[r_last_grant]) begin
          w_grant    = 1'b1;
          w_grant_ch = r_last_grant;
        end
        if (w_grant) w_state_nxt = ST_SEND;
      end
      ST_SEND: if (w_pop && w_head.eop) w_state_nxt = ST_GAP;
      ST_GAP:  if (r_ifg == IFG_LAST)   w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop  = (r_state == ST_SEND) && (r_div == '0);
    o_busy = (r_state == ST_SEND) || (r_state == ST_GAP);
  end

  // r_last_grant doubles as the channel currently being sent.
  assign w_head = (r_last_grant == CH1) ? w_rdat1 : w_rdat0;
  assign w_rd0  = w_pop & (r_last_grant == CH0);
  assign w_rd1  = w_pop & (r_last_grant == CH1);

  always_ff @(posedge i_clk) begin
    if (i_rst)        r_last_grant <= CH1;
    else if (w_grant) r_last_grant <= w_grant_ch;
  end

  // Byte divider runs only in SEND and restarts at 0 on each grant.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != ST_SEND) r_div <= '0;
    else if (r_div == DIV_LAST)      r_div <= '0;
    else                             r_div <= r_div + DIV_ONE;
  end

  // Gap counter: its first GAP clock coincides with the eop output strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != ST_GAP) r_ifg <= '0;
    else                            r_ifg <= r_ifg + IFG_ONE;
  end

  // ---------------- output registers -----------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= 1'b0;
      r_sop <= 1'b0;
      r_eop <= 1'b0;
      r_dat <= '0;
    end else begin
      r_vld <= w_pop;
      r_sop <= w_pop & w_head.sop;
      r_eop <= w_pop & w_head.eop;
      r_dat <= w_pop ? w_head.dat : 8'h00;
    end
  end

  assign o_mac_tx_vld = r_vld;
  assign o_mac_tx_sop = r_sop;
  assign o_mac_tx_eop = r_eop;
  assign o_mac_tx_dat = r_dat;
  assign o_drop       = r_drop;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mac_tx_arbiter
// Self-checking bench for mac_tx_arbiter. Packets with random payloads are
// driven on both channels; a packet-level reference model (per-channel queues
// merged by the alternating-grant rule) produces the expected output stream,
// which is compared strobe by strobe together with byte pacing, inter-frame
// spacing, first-byte latency, drop pulses and reset behaviour.
// -----------------------------------------------------------------------------
module tb_mac_tx_arbiter;

  localparam int BYTE_DIV   = 4;
  localparam int IFG_CYCLES = 48;

  logic       clk, rst;
  logic       c0_sop, c0_eop, c0_vld;
  logic [7:0] c0_dat;
  logic       c1_sop, c1_eop, c1_vld;
  logic [7:0] c1_dat;
  logic       o_sop, o_eop, o_vld, o_busy;
  logic [7:0] o_dat;
  logic [1:0] o_drop;

  mac_tx_arbiter dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_mac_packet_tx_sop (c0_sop),
    .i_mac_packet_tx_eop (c0_eop),
    .i_mac_packet_tx_vld (c0_vld),
    .i_mac_packet_tx_dat (c0_dat),
    .i_arp_tx_sop        (c1_sop),
    .i_arp_tx_eop        (c1_eop),
    .i_arp_tx_vld        (c1_vld),
    .i_arp_tx_dat        (c1_dat),
    .o_mac_tx_sop        (o_sop),
    .o_mac_tx_eop        (o_eop),
    .o_mac_tx_vld        (o_vld),
    .o_mac_tx_dat        (o_dat),
    .o_drop              (o_drop),
    .o_busy              (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model state ------------------------------------
  logic [7:0] pend0[$], pend1[$];
  int         plen0[$], plen1[$];
  int         model_last = 1;
  int         first_eop  = -1;
  logic [7:0] exp_dat[$];
  bit         exp_sop[$], exp_eop[$];

  // ---------------- output monitor -------------------------------------------
  logic [7:0] rx_dat[$];
  bit         rx_sop[$], rx_eop[$], rx_busy[$];
  int         rx_cyc[$];
  int         drop_cnt0 = 0, drop_cnt1 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_vld) begin
        rx_dat.push_back(o_dat);
        rx_sop.push_back(o_sop);
        rx_eop.push_back(o_eop);
        rx_busy.push_back(o_busy);
        rx_cyc.push_back(cyc);
      end
      if (o_drop[0]) drop_cnt0++;
      if (o_drop[1]) drop_cnt1++;
    end
  end

  // Drive one packet, one byte per clock; record it in the model if it is
  // expected to be admitted.
  task automatic drive_pkt(input int ch, input int len, input bit admit);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      d = 8'($urandom);
      if (ch == 0) begin
        c0_vld = 1'b1; c0_sop = (i == 0); c0_eop = (i == len - 1); c0_dat = d;
      end else begin
        c1_vld = 1'b1; c1_sop = (i == 0); c1_eop = (i == len - 1); c1_dat = d;
      end
      if (admit) begin
        if (ch == 0) pend0.push_back(d);
        else         pend1.push_back(d);
        if (i == len - 1 && first_eop < 0) first_eop = cyc + 1;
      end
    end
    if (admit) begin
      if (ch == 0) plen0.push_back(len);
      else         plen1.push_back(len);
    end
    @(negedge clk);
    if (ch == 0) begin
      c0_vld = 1'b0; c0_sop = 1'b0; c0_eop = 1'b0; c0_dat = 8'h00;
    end else begin
      c1_vld = 1'b0; c1_sop = 1'b0; c1_eop = 1'b0; c1_dat = 8'h00;
    end
  endtask

  // Merge pending packets: the channel that did not send last goes first when
  // it has a packet, otherwise the last channel sends again.
  task automatic build_expected();
    int pick, len;
    while (plen0.size() > 0 || plen1.size() > 0) begin
      pick = 1 - model_last;
      if ((pick == 0 && plen0.size() == 0) || (pick == 1 && plen1.size() == 0))
        pick = model_last;
      len = (pick == 0) ? plen0.pop_front() : plen1.pop_front();
      for (int i = 0; i < len; i++) begin
        exp_dat.push_back((pick == 0) ? pend0.pop_front() : pend1.pop_front());
        exp_sop.push_back(i == 0);
        exp_eop.push_back(i == len - 1);
      end
      model_last = pick;
    end
  endtask

  task automatic clear_rx();
    rx_dat.delete(); rx_sop.delete(); rx_eop.delete();
    rx_busy.delete(); rx_cyc.delete();
  endtask

  task automatic check_stream(input string name);
    int budget = 0;
    int want;
    while (rx_dat.size() < exp_dat.size() && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    repeat (IFG_CYCLES + 12) @(negedge clk);
    n_checks++;
    if (rx_dat.size() != exp_dat.size()) begin
      n_fail++;
      $display("FAIL %s strobe count: got %0d, expected %0d", name, rx_dat.size(), exp_dat.size());
    end
    for (int k = 0; k < exp_dat.size() && k < rx_dat.size(); k++) begin
      n_checks++;
      if ({rx_sop[k], rx_eop[k], rx_dat[k]} !== {exp_sop[k], exp_eop[k], exp_dat[k]}) begin
        n_fail++;
        $display("FAIL %s byte %0d {sop,eop,dat}: got %b %b %h, expected %b %b %h", name, k,
                 rx_sop[k], rx_eop[k], rx_dat[k], exp_sop[k], exp_eop[k], exp_dat[k]);
      end
      n_checks++;
      if (rx_busy[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s byte %0d busy: got %b, expected 1", name, k, rx_busy[k]);
      end
      if (k > 0) begin
        want = exp_sop[k] ? (IFG_CYCLES + 2) : BYTE_DIV;
        n_checks++;
        if (rx_cyc[k] - rx_cyc[k-1] != want) begin
          n_fail++;
          $display("FAIL %s byte %0d spacing: got %0d clocks, expected %0d", name, k,
                   rx_cyc[k] - rx_cyc[k-1], want);
        end
      end
    end
    if (rx_dat.size() > 0 && exp_dat.size() > 0) begin
      n_checks++;
      if (rx_cyc[0] != first_eop + 2) begin
        n_fail++;
        $display("FAIL %s first-byte latency: got cycle %0d, expected %0d", name, rx_cyc[0], first_eop + 2);
      end
    end
    exp_dat.delete(); exp_sop.delete(); exp_eop.delete();
    clear_rx();
    first_eop = -1;
  endtask

  // ---------------- scenarios ------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_vld, o_sop, o_eop, o_dat, o_drop, o_busy} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset outputs: got %h, expected 0", {o_vld, o_sop, o_eop, o_dat, o_drop, o_busy});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({o_vld, o_busy, o_drop} !== 4'h0 || rx_dat.size() != 0) begin
      n_fail++;
      $display("FAIL idle after reset: vld/busy/drop %b, strobes %0d, expected 0", {o_vld, o_busy, o_drop}, rx_dat.size());
    end
  endtask

  task automatic test_single_ch1();
    drive_pkt(1, 60, 1'b1);
    build_expected();
    check_stream("single_ch1");
  endtask

  task automatic test_both_ready();
    fork
      drive_pkt(0, 100, 1'b1);
      begin
        repeat (40) @(negedge clk);
        drive_pkt(1, 60, 1'b1);
      end
    join
    build_expected();
    check_stream("both_ready");
  endtask

  task automatic test_back_to_back();
    int l0[3], l1[3];
    for (int i = 0; i < 3; i++) begin
      l0[i] = $urandom_range(21, 10);
      l1[i] = $urandom_range(21, 10);
    end
    drive_pkt(0, l0[0], 1'b1);
    fork
      for (int i = 0; i < 3; i++) drive_pkt(1, l1[i], 1'b1);
      for (int j = 1; j < 3; j++) drive_pkt(0, l0[j], 1'b1);
    join
    build_expected();
    check_stream("back_to_back");
  endtask

  task automatic test_one_byte();
    drive_pkt(0, 1, 1'b1);
    build_expected();
    check_stream("one_byte");
  endtask

  task automatic test_drop();
    drop_cnt0 = 0;
    drop_cnt1 = 0;
    drive_pkt(1, 64, 1'b1);
    drive_pkt(1, 64, 1'b1);
    drive_pkt(1, 10, 1'b0);
    build_expected();
    check_stream("drop");
    n_checks++;
    if (drop_cnt1 != 1) begin
      n_fail++;
      $display("FAIL drop ch1 pulse clocks: got %0d, expected 1", drop_cnt1);
    end
    n_checks++;
    if (drop_cnt0 != 0) begin
      n_fail++;
      $display("FAIL drop ch0 pulse clocks: got %0d, expected 0", drop_cnt0);
    end
  endtask

  task automatic test_reset_mid_send();
    int budget = 0;
    drive_pkt(0, 100, 1'b1);
    while (rx_dat.size() < 31 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    n_checks++;
    if (rx_dat.size() < 31) begin
      n_fail++;
      $display("FAIL reset_mid_send reach byte 30: got %0d strobes, expected 31", rx_dat.size());
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_vld, o_sop, o_eop, o_dat, o_drop, o_busy} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_mid_send outputs: got %h, expected 0", {o_vld, o_sop, o_eop, o_dat, o_drop, o_busy});
    end
    rst = 1'b0;
    pend0.delete(); pend1.delete(); plen0.delete(); plen1.delete();
    exp_dat.delete(); exp_sop.delete(); exp_eop.delete();
    model_last = 1;
    first_eop  = -1;
    clear_rx();
    repeat (20) @(negedge clk);
    n_checks++;
    if (rx_dat.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_send residue: got %0d strobes, expected 0", rx_dat.size());
    end
    drive_pkt(0, 20, 1'b1);
    build_expected();
    check_stream("post_reset");
  endtask

  initial begin
    rst = 1'b1;
    c0_sop = 1'b0; c0_eop = 1'b0; c0_vld = 1'b0; c0_dat = 8'h00;
    c1_sop = 1'b0; c1_eop = 1'b0; c1_vld = 1'b0; c1_dat = 8'h00;
    test_reset();
    test_single_ch1();
    test_both_ready();
    test_back_to_back();
    test_one_byte();
    test_drop();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
